// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the pipeline hazard controller
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_LU_STALL = 2'b01,
    ST_MEM_WAIT = 2'b10
  } hz_state_t;

  localparam int REG_ZERO = 0;

endpackage

// File: rtl/hazard_fwd_sel.sv
// rtl/hazard_fwd_sel.sv - E-stage operand forward select for one source register
module hazard_fwd_sel
  import hazard_pkg::*;
#(
  parameter int RW = 5
) (
  input  logic [RW-1:0] src,
  input  logic [RW-1:0] rdM,
  input  logic          regWrM,
  input  logic [RW-1:0] rdW,
  input  logic          regWrW,
  output fwd_sel_t      sel
);

  // M is younger than W, so its result wins when both target the same register
  always_comb begin
    sel = FWD_RF;
    if (src != RW'(REG_ZERO)) begin
      if (regWrM && (rdM == src)) begin
        sel = FWD_MEM;
      end else if (regWrW && (rdW == src)) begin
        sel = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - load-use/branch/memory-wait hazard control with E-stage forwarding
// Optional perf counters are built when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int NREG     = 19,
  parameter int LU_STALL = 1,
  parameter int MEM_TMO  = 255,
  parameter int CNT_W    = 16,
  localparam int RW      = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [RW-1:0]    rs1_d,
  input  logic [RW-1:0]    rs2_d,
  input  logic             use1_d,
  input  logic             use2_d,
  input  logic             valid_d,
  input  logic [RW-1:0]    rs1_e,
  input  logic [RW-1:0]    rs2_e,
  input  logic [RW-1:0]    rd_e,
  input  logic             regwr_e,
  input  logic             load_e,
  input  logic             pcsrc_e,
  input  logic [RW-1:0]    rd_m,
  input  logic             regwr_m,
  input  logic             mem_busy_m,
  input  logic [RW-1:0]    rd_w,
  input  logic             regwr_w,
  output logic [1:0]       fwd_a_e,
  output logic [1:0]       fwd_b_e,
  output logic             stall_f,
  output logic             stall_d,
  output logic             stall_e,
  output logic             stall_m,
  output logic             flush_d,
  output logic             flush_e,
  output logic             wb_valid_o,
  output logic             mem_tmo_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic [CNT_W-1:0] fwd_cnt_o
);

  localparam int TW = (MEM_TMO < 2) ? 1 : $clog2(MEM_TMO + 1);

  hz_state_t     state, nextState;
  logic [1:0]    luCnt, nextLuCnt;
  logic [TW-1:0] tmoCnt;
  logic          memTmo;
  fwd_sel_t      fwdA, fwdB;
  logic          luHit;
  logic          sF, sD, sE, sM, fD, fE, wbValid;

  hazard_fwd_sel #(.RW(RW)) uFwdA (
    .src(rs1_e), .rdM(rd_m), .regWrM(regwr_m), .rdW(rd_w), .regWrW(regwr_w), .sel(fwdA)
  );

  hazard_fwd_sel #(.RW(RW)) uFwdB (
    .src(rs2_e), .rdM(rd_m), .regWrM(regwr_m), .rdW(rd_w), .regWrW(regwr_w), .sel(fwdB)
  );

  assign luHit = valid_d && load_e && regwr_e && (rd_e != RW'(REG_ZERO)) &&
                 ((use1_d && (rs1_d == rd_e)) || (use2_d && (rs2_d == rd_e)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_RUN;
      luCnt <= '0;
    end else begin
      state <= nextState;
      luCnt <= nextLuCnt;
    end
  end

  always_comb begin
    nextState = state;
    nextLuCnt = luCnt;
    sF        = 1'b0;
    sD        = 1'b0;
    sE        = 1'b0;
    sM        = 1'b0;
    fD        = 1'b0;
    fE        = 1'b0;
    wbValid   = 1'b1;
    case (state)
      ST_LU_STALL: begin
        if (mem_busy_m) begin
          {sF, sD, sE, sM} = 4'b1111;
          wbValid   = 1'b0;
          nextState = ST_MEM_WAIT;
        end else begin
          sF        = 1'b1;
          sD        = 1'b1;
          fE        = 1'b1;
          nextLuCnt = luCnt - 2'd1;
          if (luCnt == 2'd1) nextState = ST_RUN;
        end
      end
      default: begin
        // A released MEM_WAIT resolves exactly like RUN in the same cycle
        if (mem_busy_m) begin
          {sF, sD, sE, sM} = 4'b1111;
          wbValid   = 1'b0;
          nextState = ST_MEM_WAIT;
        end else if (pcsrc_e) begin
          fD        = 1'b1;
          fE        = 1'b1;
          nextState = ST_RUN;
        end else if (luHit) begin
          sF = 1'b1;
          sD = 1'b1;
          fE = 1'b1;
          if (LU_STALL > 1) begin
            nextState = ST_LU_STALL;
            nextLuCnt = 2'(LU_STALL - 1);
          end else begin
            nextState = ST_RUN;
          end
        end else begin
          nextState = ST_RUN;
        end
      end
    endcase
    if (reset) begin
      {sF, sD, sE, sM, fD, fE} = 6'b0;
      wbValid = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmoCnt <= '0;
      memTmo <= 1'b0;
    end else if (!mem_busy_m) begin
      tmoCnt <= '0;
    end else begin
      if (tmoCnt != '1) tmoCnt <= tmoCnt + 1'b1;
      if ((MEM_TMO != 0) && (tmoCnt == TW'(MEM_TMO - 1))) memTmo <= 1'b1;
    end
  end

  assign fwd_a_e    = reset ? FWD_RF : fwdA;
  assign fwd_b_e    = reset ? FWD_RF : fwdB;
  assign stall_f    = sF;
  assign stall_d    = sD;
  assign stall_e    = sE;
  assign stall_m    = sM;
  assign flush_d    = fD;
  assign flush_e    = fE;
  assign wb_valid_o = wbValid;
  assign mem_tmo_o  = memTmo;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stallCnt, flushCnt, fwdCnt;
  logic             anyStall, anyFlush, anyFwd;

  assign anyStall = sF | sD | sE | sM;
  assign anyFlush = fD | fE;
  assign anyFwd   = (fwd_a_e != 2'b00) || (fwd_b_e != 2'b00);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stallCnt <= '0;
      flushCnt <= '0;
      fwdCnt   <= '0;
    end else begin
      if (anyStall && (stallCnt != '1)) stallCnt <= stallCnt + 1'b1;
      if (anyFlush && (flushCnt != '1)) flushCnt <= flushCnt + 1'b1;
      if (anyFwd && (fwdCnt != '1))     fwdCnt   <= fwdCnt + 1'b1;
    end
  end

  assign stall_cnt_o = stallCnt;
  assign flush_cnt_o = flushCnt;
  assign fwd_cnt_o   = fwdCnt;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
  assign fwd_cnt_o   = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed vector bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

  localparam int RW    = 5;
  localparam int CNT_W = 4;

  logic clk, reset;
  logic [RW-1:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic use1_d, use2_d, valid_d, regwr_e, load_e, pcsrc_e, regwr_m, mem_busy_m, regwr_w;
  logic [1:0] fwd_a_e, fwd_b_e;
  logic stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, wb_valid_o, mem_tmo_o;
  logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o, fwd_cnt_o;
  logic [10:0] outs;

  int nChecks = 0;
  int nFail   = 0;

  typedef struct {
    logic [RW-1:0] rs1e, rs2e, rdm;
    logic          regwrm;
    logic [RW-1:0] rdw;
    logic          regwrw, validd;
    logic [RW-1:0] rs1d, rs2d;
    logic          use1, use2;
    logic [RW-1:0] rde;
    logic          regwre, loade, pcsrc;
    logic [10:0]   exp;   // {fwdA, fwdB, stallF/D/E/M, flushD/E, wbValid}
    string         name;
  } vec_t;

  vec_t vecs[13];

  pipeline_hazard_ctrl #(.NREG(19), .LU_STALL(2), .MEM_TMO(3), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .use1_d(use1_d), .use2_d(use2_d), .valid_d(valid_d),
    .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e), .regwr_e(regwr_e), .load_e(load_e),
    .pcsrc_e(pcsrc_e), .rd_m(rd_m), .regwr_m(regwr_m), .mem_busy_m(mem_busy_m),
    .rd_w(rd_w), .regwr_w(regwr_w),
    .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
    .flush_d(flush_d), .flush_e(flush_e), .wb_valid_o(wb_valid_o), .mem_tmo_o(mem_tmo_o),
    .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o), .fwd_cnt_o(fwd_cnt_o)
  );

  assign outs = {fwd_a_e, fwd_b_e, stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, wb_valid_o};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clearIn();
    {rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w} = '0;
    {use1_d, use2_d, valid_d, regwr_e, load_e, pcsrc_e, regwr_m, mem_busy_m, regwr_w} = '0;
  endtask

  task automatic doReset();
    clearIn();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic applyVec(input vec_t v);
    rs1_e = v.rs1e;  rs2_e = v.rs2e;  rd_m = v.rdm;  regwr_m = v.regwrm;
    rd_w = v.rdw;    regwr_w = v.regwrw; valid_d = v.validd;
    rs1_d = v.rs1d;  rs2_d = v.rs2d;  use1_d = v.use1; use2_d = v.use2;
    rd_e = v.rde;    regwr_e = v.regwre; load_e = v.loade; pcsrc_e = v.pcsrc;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  localparam logic [10:0] IDLE  = 11'b00_00_0000_00_1;
  localparam logic [10:0] LUSTL = 11'b00_00_1100_01_1;
  localparam logic [10:0] BRFL  = 11'b00_00_0000_11_1;

  initial begin
    vecs[0]  = '{5, 3, 5, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 11'b10_00_0000_00_1, "fwd M over W"};
    vecs[1]  = '{5, 3, 6, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 11'b01_00_0000_00_1, "fwd W"};
    vecs[2]  = '{0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE, "fwd r0 never"};
    vecs[3]  = '{6, 6, 6, 0, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 11'b01_01_0000_00_1, "fwd W both"};
    vecs[4]  = '{1, 9, 9, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 11'b00_10_0000_00_1, "fwd B M"};
    vecs[5]  = '{0, 0, 0, 0, 0, 0, 1, 0, 7, 0, 1, 7, 1, 1, 0, LUSTL, "lu hit rs2"};
    vecs[6]  = '{0, 0, 0, 0, 0, 0, 1, 0, 7, 0, 0, 7, 1, 1, 0, IDLE, "lu no use2"};
    vecs[7]  = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 0, 1, 1, 0, IDLE, "lu rd r0"};
    vecs[8]  = '{0, 0, 0, 0, 0, 0, 0, 0, 7, 0, 1, 7, 1, 1, 0, IDLE, "lu not valid"};
    vecs[9]  = '{0, 0, 0, 0, 0, 0, 1, 0, 7, 0, 1, 7, 1, 0, 0, IDLE, "lu not load"};
    vecs[10] = '{0, 0, 0, 0, 0, 0, 1, 0, 7, 0, 1, 7, 1, 1, 1, BRFL, "branch over lu"};
    vecs[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, BRFL, "branch only"};
    vecs[12] = '{0, 0, 0, 0, 0, 0, 1, 12, 0, 1, 0, 12, 1, 1, 0, LUSTL, "lu hit rs1"};

    // Reset state
    clearIn();
    reset = 1'b1;
    #2;
    check("reset outs", 32'(outs), 32'(IDLE));
    check("reset tmo", 32'(mem_tmo_o), 0);
    check("reset cnts", {stall_cnt_o, flush_cnt_o, fwd_cnt_o}, 0);
    step();
    reset = 1'b0;

    // Combinational vectors, each from a fresh RUN state
    for (int i = 0; i < 13; i++) begin
      doReset();
      applyVec(vecs[i]);
      #3;
      check(vecs[i].name, 32'(outs), 32'(vecs[i].exp));
    end

    // Load-use with LU_STALL=2 holds for exactly two cycles
    doReset();
    applyVec(vecs[5]);
    #3;
    check("lu seq c1", 32'(outs), 32'(LUSTL));
    step();
    clearIn();
    #3;
    check("lu seq c2", 32'(outs), 32'(LUSTL));
    step();
    #3;
    check("lu seq c3", 32'(outs), 32'(IDLE));

    // Branch beats load-use and no stall state follows
    doReset();
    applyVec(vecs[10]);
    #3;
    check("br+lu c1", 32'(outs), 32'(BRFL));
    step();
    clearIn();
    #3;
    check("br+lu c2", 32'(outs), 32'(IDLE));

    // Memory wait, MEM_TMO=3; branch during the wait is ignored
    doReset();
    mem_busy_m = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      if (c == 2) pcsrc_e = 1'b1;
      #3;
      check($sformatf("memwait c%0d", c),
            {stall_f, stall_d, stall_e, stall_m, wb_valid_o, flush_d, flush_e, mem_tmo_o},
            {4'b1111, 1'b0, 2'b00, (c == 4)});
      step();
    end
    mem_busy_m = 1'b0;
    pcsrc_e    = 1'b0;
    #3;
    check("memwait release",
          {stall_f, stall_d, stall_e, stall_m, wb_valid_o, flush_d, flush_e, mem_tmo_o},
          {4'b0000, 1'b1, 2'b00, 1'b1});

    // Asynchronous reset while in LU_STALL
    doReset();
    applyVec(vecs[5]);
    step();
    #2;
    reset = 1'b1;
    #1;
    check("async reset outs", 32'(outs), 32'(IDLE));
    clearIn();
    step();
    reset = 1'b0;
    #3;
    check("after reset no stall", 32'(outs), 32'(IDLE));

    // Perf counters: 20 stall cycles saturate a 4-bit counter
    doReset();
    mem_busy_m = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    mem_busy_m = 1'b0;
`ifdef HAZARD_PERF_CNT_EN
    check("stall cnt sat", 32'(stall_cnt_o), 15);
`else
    check("stall cnt off", 32'(stall_cnt_o), 0);
`endif
    check("flush cnt", 32'(flush_cnt_o), 0);
    check("fwd cnt", 32'(fwd_cnt_o), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
